// File: rtl/pipe_pkg.sv
// Shared pipeline types for decode, ID/EX register and execute stage:
// the control bundle, its all-zero NOP value, field geometry and small helpers.
package pipe_pkg;

    localparam int INSTR_W = 18;
    localparam int ADDR_W  = 10;
    localparam int DATA_W  = 8;
    localparam int ADR_W   = 5;
    localparam int CNT_W   = 8;
    localparam int ADRX_HI = 12;
    localparam int ADRX_LO = 8;
    localparam int ADRY_HI = 7;
    localparam int ADRY_LO = 3;

    localparam logic [CNT_W-1:0] CNT_MAX = 8'hFF;
    localparam logic [CNT_W-1:0] CNT_ONE = 8'h01;

    typedef struct packed {
        logic       rf_wr;
        logic [1:0] rf_wr_sel;
        logic       alu_opy_sel;
        logic [3:0] alu_sel;
        logic       scr_we;
        logic       scr_data_sel;
        logic [1:0] scr_addr_sel;
        logic       flg_c_ld;
        logic       flg_c_set;
        logic       flg_c_clr;
        logic       flg_z_ld;
        logic       i_set;
        logic       i_clr;
        logic       io_strobe;
        logic [2:0] branch_type;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '{default: '0};

    // True when either source register of the incoming instruction names tag.
    function automatic logic adr_hit(input logic [ADR_W-1:0] tag,
                                     input logic [ADR_W-1:0] adrx,
                                     input logic [ADR_W-1:0] adry);
        return (tag == adrx) || (tag == adry);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == CNT_MAX) begin
            return v;
        end else begin
            return v + CNT_ONE;
        end
    endfunction

endpackage

// File: rtl/id_ex_reg_if.sv
// Decode-to-execute bundle: decode-side inputs, execute-stage contents,
// hazard request and bubble counter.
interface id_ex_reg_if;
    import pipe_pkg::*;

    logic                in_valid;
    logic [INSTR_W-1:0]  in_instr;
    logic [ADDR_W-1:0]   in_addr;
    logic [DATA_W-1:0]   in_dx;
    logic [DATA_W-1:0]   in_dy;
    ctrl_t               in_ctrl;
    logic                stall_in;
    logic                flush;
    logic                hz_stall;
    logic                ex_valid;
    logic [INSTR_W-1:0]  ex_instr;
    logic [ADDR_W-1:0]   ex_addr;
    logic [DATA_W-1:0]   ex_dx;
    logic [DATA_W-1:0]   ex_dy;
    ctrl_t               ex_ctrl;
    logic [CNT_W-1:0]    bubble_cnt;

    modport master (
        output in_valid, in_instr, in_addr, in_dx, in_dy, in_ctrl, stall_in, flush,
        input  hz_stall, ex_valid, ex_instr, ex_addr, ex_dx, ex_dy, ex_ctrl, bubble_cnt
    );

    modport slave (
        input  in_valid, in_instr, in_addr, in_dx, in_dy, in_ctrl, stall_in, flush,
        output hz_stall, ex_valid, ex_instr, ex_addr, ex_dx, ex_dy, ex_ctrl, bubble_cnt
    );

endinterface

// File: rtl/id_ex_reg_hazard_detect.sv
// RAW hazard check of the decode-slot source registers against the EX
// destination and the one-entry writeback tag. Purely combinational.
module hazard_detect
    import pipe_pkg::*;
(
    input  logic             in_valid,
    input  logic             flush,
    input  logic [ADR_W-1:0] adrx,
    input  logic [ADR_W-1:0] adry,
    input  logic             ex_wr,
    input  logic [ADR_W-1:0] ex_adr,
    input  logic             wb_v,
    input  logic [ADR_W-1:0] wb_adr,
    output logic             hz_stall
);

    // ADRY is compared even for instructions that do not read it (conservative).
    always_comb begin
        hz_stall = 1'b0;
        if (in_valid && !flush) begin
            hz_stall = (ex_wr && adr_hit(ex_adr, adrx, adry)) ||
                       (wb_v  && adr_hit(wb_adr, adrx, adry));
        end else begin
            hz_stall = 1'b0;
        end
    end

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with writeback tag, RAW bubble insertion and a
// saturating bubble counter. Priority per edge: flush > stall_in > hazard > load.
module id_ex_reg
    import pipe_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    id_ex_reg_if.slave  bus
);

    logic                valid_r;
    logic [INSTR_W-1:0]  instr_r;
    logic [ADDR_W-1:0]   addr_r;
    logic [DATA_W-1:0]   dx_r;
    logic [DATA_W-1:0]   dy_r;
    ctrl_t               ctrl_r;
    logic                wb_v_r;
    logic [ADR_W-1:0]    wb_adr_r;
    logic [CNT_W-1:0]    bubble_cnt_r;

    logic                ex_wr_s;
    logic [ADR_W-1:0]    ex_adr_s;
    logic                hz_s;

    assign ex_wr_s  = valid_r & ctrl_r.rf_wr;
    assign ex_adr_s = instr_r[ADRX_HI:ADRX_LO];

    hazard_detect u_hazard_detect (
        .in_valid (bus.in_valid),
        .flush    (bus.flush),
        .adrx     (bus.in_instr[ADRX_HI:ADRX_LO]),
        .adry     (bus.in_instr[ADRY_HI:ADRY_LO]),
        .ex_wr    (ex_wr_s),
        .ex_adr   (ex_adr_s),
        .wb_v     (wb_v_r),
        .wb_adr   (wb_adr_r),
        .hz_stall (hz_s)
    );

    // Stage register, writeback tag and bubble counter update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r      <= 1'b0;
            instr_r      <= '0;
            addr_r       <= '0;
            dx_r         <= '0;
            dy_r         <= '0;
            ctrl_r       <= CTRL_NOP;
            wb_v_r       <= 1'b0;
            wb_adr_r     <= '0;
            bubble_cnt_r <= '0;
        end else if (bus.flush) begin
            valid_r  <= 1'b0;
            ctrl_r   <= CTRL_NOP;
            wb_v_r   <= ex_wr_s;
            wb_adr_r <= ex_adr_s;
        end else if (bus.stall_in) begin
            valid_r  <= valid_r;
            ctrl_r   <= ctrl_r;
        end else if (hz_s) begin
            valid_r      <= 1'b0;
            ctrl_r       <= CTRL_NOP;
            wb_v_r       <= ex_wr_s;
            wb_adr_r     <= ex_adr_s;
            bubble_cnt_r <= sat_inc(bubble_cnt_r);
        end else begin
            valid_r  <= bus.in_valid;
            instr_r  <= bus.in_instr;
            addr_r   <= bus.in_addr;
            dx_r     <= bus.in_dx;
            dy_r     <= bus.in_dy;
            // An empty slot must never carry live control into execute.
            ctrl_r   <= bus.in_valid ? bus.in_ctrl : CTRL_NOP;
            wb_v_r   <= ex_wr_s;
            wb_adr_r <= ex_adr_s;
        end
    end

    assign bus.hz_stall   = hz_s;
    assign bus.ex_valid   = valid_r;
    assign bus.ex_instr   = instr_r;
    assign bus.ex_addr    = addr_r;
    assign bus.ex_dx      = dx_r;
    assign bus.ex_dy      = dy_r;
    assign bus.ex_ctrl    = ctrl_r;
    assign bus.bubble_cnt = bubble_cnt_r;

endmodule

// File: tb/tb_id_ex_reg.sv
// Directed bench for id_ex_reg: load, EX/WB hazards, stall, flush, saturation
// and asynchronous reset, each against hand-computed values.
module tb_id_ex_reg;
    import pipe_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   nvec = 0;
    int   nerr = 0;

    always #5 clk = ~clk;

    id_ex_reg_if bus ();

    id_ex_reg dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [17:0] ins, input logic [9:0] ad,
                         input logic [7:0] dx, input logic [7:0] dy, input ctrl_t c);
        bus.in_valid = v;
        bus.in_instr = ins;
        bus.in_addr  = ad;
        bus.in_dx    = dx;
        bus.in_dy    = dy;
        bus.in_ctrl  = c;
    endtask

    ctrl_t c_wr;
    ctrl_t c_nowr;
    logic  found;

    initial begin
        c_wr         = CTRL_NOP;
        c_wr.rf_wr   = 1'b1;
        c_wr.alu_sel = 4'h3;
        c_nowr           = CTRL_NOP;
        c_nowr.alu_sel   = 4'h2;
        c_nowr.io_strobe = 1'b1;

        rst_n        = 1'b0;
        bus.stall_in = 1'b0;
        bus.flush    = 1'b0;
        drive(1'b0, 18'h0, 10'h0, 8'h0, 8'h0, CTRL_NOP);
        #1;
        chk("rst_valid", 32'(bus.ex_valid), 32'h0);
        chk("rst_instr", 32'(bus.ex_instr), 32'h0);
        chk("rst_ctrl",  32'(bus.ex_ctrl), 32'h0);
        chk("rst_cnt",   32'(bus.bubble_cnt), 32'h0);
        chk("rst_hz",    32'(bus.hz_stall), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Load: ADRX=5, ADRY=1, writes r5.
        drive(1'b1, 18'h0A508, 10'h123, 8'h11, 8'h22, c_wr);
        #1;
        chk("load_hz", 32'(bus.hz_stall), 32'h0);
        tick();
        chk("load_valid", 32'(bus.ex_valid), 32'h1);
        chk("load_instr", 32'(bus.ex_instr), 32'h0A508);
        chk("load_addr",  32'(bus.ex_addr), 32'h123);
        chk("load_dx",    32'(bus.ex_dx), 32'h11);
        chk("load_dy",    32'(bus.ex_dy), 32'h22);
        chk("load_ctrl",  32'(bus.ex_ctrl), 32'(c_wr));

        // EX hazard: ADRX=5 against EX writing r5 -> two bubbles.
        drive(1'b1, 18'h00510, 10'h124, 8'h33, 8'h44, c_nowr);
        #1;
        chk("exhz_hz0", 32'(bus.hz_stall), 32'h1);
        tick();
        chk("exhz_b1_valid", 32'(bus.ex_valid), 32'h0);
        chk("exhz_b1_ctrl",  32'(bus.ex_ctrl), 32'h0);
        chk("exhz_b1_cnt",   32'(bus.bubble_cnt), 32'h1);
        chk("exhz_hz1",      32'(bus.hz_stall), 32'h1);
        tick();
        chk("exhz_b2_cnt",   32'(bus.bubble_cnt), 32'h2);
        chk("exhz_hz2",      32'(bus.hz_stall), 32'h0);
        tick();
        chk("exhz_ld_valid", 32'(bus.ex_valid), 32'h1);
        chk("exhz_ld_instr", 32'(bus.ex_instr), 32'h00510);
        chk("exhz_ld_cnt",   32'(bus.bubble_cnt), 32'h2);

        // WB-only hazard: A writes r7, B unrelated, C reads r7 as ADRY -> one bubble.
        drive(1'b1, 18'h00700, 10'h130, 8'h01, 8'h02, c_wr);
        tick();
        drive(1'b1, 18'h00108, 10'h131, 8'h03, 8'h04, c_nowr);
        #1;
        chk("wbhz_b_hz", 32'(bus.hz_stall), 32'h0);
        tick();
        drive(1'b1, 18'h00238, 10'h132, 8'h05, 8'h06, c_wr);
        #1;
        chk("wbhz_c_hz", 32'(bus.hz_stall), 32'h1);
        tick();
        chk("wbhz_b_cnt", 32'(bus.bubble_cnt), 32'h3);
        chk("wbhz_hz_clr", 32'(bus.hz_stall), 32'h0);
        tick();
        chk("wbhz_ld_instr", 32'(bus.ex_instr), 32'h00238);
        chk("wbhz_ld_cnt",   32'(bus.bubble_cnt), 32'h3);

        // Stall for three edges with a pending hazard on r2: nothing moves.
        bus.stall_in = 1'b1;
        drive(1'b1, 18'h00200, 10'h140, 8'h07, 8'h08, c_nowr);
        #1;
        chk("stall_hz", 32'(bus.hz_stall), 32'h1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_valid", 32'(bus.ex_valid), 32'h1);
            chk("stall_instr", 32'(bus.ex_instr), 32'h00238);
            chk("stall_dx",    32'(bus.ex_dx), 32'h05);
            chk("stall_ctrl",  32'(bus.ex_ctrl), 32'(c_wr));
            chk("stall_cnt",   32'(bus.bubble_cnt), 32'h3);
        end

        // Flush overrides stall.
        bus.flush = 1'b1;
        #1;
        chk("flush_hz", 32'(bus.hz_stall), 32'h0);
        tick();
        chk("flush_valid", 32'(bus.ex_valid), 32'h0);
        chk("flush_ctrl",  32'(bus.ex_ctrl), 32'h0);
        chk("flush_cnt",   32'(bus.bubble_cnt), 32'h3);
        bus.flush    = 1'b0;
        bus.stall_in = 1'b0;

        // Empty slot with non-zero control: control forced to NOP.
        drive(1'b0, 18'h00200, 10'h141, 8'h09, 8'h0A, c_wr);
        #1;
        chk("empty_hz", 32'(bus.hz_stall), 32'h0);
        tick();
        chk("empty_valid", 32'(bus.ex_valid), 32'h0);
        chk("empty_ctrl",  32'(bus.ex_ctrl), 32'h0);

        // Self-dependent writer held at input: load, bubble, bubble repeating.
        drive(1'b1, 18'h00900, 10'h150, 8'h0B, 8'h0C, c_wr);
        tick();
        chk("sat_ld_valid", 32'(bus.ex_valid), 32'h1);
        chk("sat_ld_hz",    32'(bus.hz_stall), 32'h1);
        tick();
        tick();
        chk("sat_cnt5", 32'(bus.bubble_cnt), 32'h5);
        for (int i = 0; i < 450; i++) tick();
        chk("sat_ff", 32'(bus.bubble_cnt), 32'hFF);
        for (int i = 0; i < 9; i++) tick();
        chk("sat_hold", 32'(bus.bubble_cnt), 32'hFF);

        // Asynchronous reset while a bubble is pending.
        found = 1'b0;
        for (int i = 0; i < 4 && !found; i++) begin
            if (bus.ex_valid == 1'b0 && bus.hz_stall == 1'b1) found = 1'b1;
            else tick();
        end
        chk("midbub_reached", 32'(found), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(bus.ex_valid), 32'h0);
        chk("arst_instr", 32'(bus.ex_instr), 32'h0);
        chk("arst_dx",    32'(bus.ex_dx), 32'h0);
        chk("arst_ctrl",  32'(bus.ex_ctrl), 32'h0);
        chk("arst_cnt",   32'(bus.bubble_cnt), 32'h0);
        chk("arst_hz",    32'(bus.hz_stall), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 18'h0A508, 10'h200, 8'h11, 8'h12, c_nowr);
        tick();
        chk("post_rst_valid", 32'(bus.ex_valid), 32'h1);
        chk("post_rst_instr", 32'(bus.ex_instr), 32'h0A508);
        chk("post_rst_cnt",   32'(bus.bubble_cnt), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/id_ex_reg.md
ID_EX_REG -- requirements
Module: id_ex_reg

Interface
REQ-001 SHALL have port clk  input  1  single rising-edge clock for all state.
REQ-002 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port in_valid  input  1  decode slot holds a real instruction.
REQ-004 SHALL have port in_instr  input  18  instruction from fetch register; [12:8]=ADRX, [7:3]=ADRY.
REQ-005 SHALL have port in_addr  input  10  program address of in_instr.
REQ-006 SHALL have ports in_dx / in_dy  input  8 each  register-file read data.
REQ-007 SHALL have port in_ctrl  input  ctrl_t  decoder control bundle (rf_wr, rf_wr_sel, alu_opy_sel, alu_sel, scr_we, scr_data_sel, scr_addr_sel, flag controls, i_set/i_clr, io_strobe, branch_type).
REQ-008 SHALL have port stall_in  input  1  downstream/memory stall; freeze stage.
REQ-009 SHALL have port flush  input  1  branch taken or interrupt; kill stage.
REQ-010 SHALL have port hz_stall  output  1  combinational RAW-hazard request to hold PC and fetch register.
REQ-011 SHALL have ports ex_valid, ex_instr(18), ex_addr(10), ex_dx(8), ex_dy(8), ex_ctrl(ctrl_t)  output  registered execute-stage contents.
REQ-012 SHALL have port bubble_cnt  output  8  saturating count of inserted bubbles.

Function
REQ-013 SHALL hold one stage register {valid, instr, addr, dx, dy, ctrl} plus a one-entry writeback tag {wb_v, wb_adr[4:0]}.
REQ-014 SHALL define ex_wr = ex_valid & ex_ctrl.rf_wr, ex_adr = ex_instr[12:8].
REQ-015 SHALL assert hz_stall = in_valid & ~flush & ((ex_wr & (ex_adr==in ADRX | ex_adr==in ADRY)) | (wb_v & (wb_adr==in ADRX | wb_adr==in ADRY))); ADRY compared unconditionally (conservative).
REQ-016 SHALL update per rising edge with priority flush > stall_in > hazard > load.
REQ-017 flush: valid<=0, ctrl<=all-zero, other data don't-care; wb tag still advances from the current stage; flush overrides stall_in.
REQ-018 stall_in (no flush): stage register and wb tag hold unchanged; bubble_cnt unchanged.
REQ-019 hazard (no flush/stall_in): valid<=0, ctrl<=all-zero (bubble); wb tag advances; bubble_cnt increments.
REQ-020 load: stage <= inputs, valid<=in_valid; when in_valid=0 ctrl SHALL be forced to zero.
REQ-021 wb tag advance: wb_v<=ex_wr, wb_adr<=ex_adr.
REQ-022 SHALL give one-cycle latency input-to-ex_*; a hazard against EX SHALL yield exactly two bubbles, against WB only exactly one.
REQ-023 bubble_cnt SHALL saturate at 8'hFF and never wrap.
REQ-024 Invalid stage contents SHALL never cause a write, strobe or flag change downstream (ctrl all-zero).

Reset
REQ-025 On rst_n low, asynchronously: ex_valid=0, ex_instr=0, ex_addr=0, ex_dx=0, ex_dy=0, ex_ctrl=0, wb_v=0, wb_adr=0, bubble_cnt=0; hz_stall thereby 0.
REQ-026 Reset mid-stall or mid-bubble SHALL discard all state; first edge after release SHALL behave as load.

Structure
REQ-027 ctrl_t packed struct, CTRL_NOP all-zero constant and field widths SHALL live in shared package pipe_pkg, reused by the decoder and execute stage.
REQ-028 Hazard comparison SHALL be one sub-module hazard_detect (pure combinational); stage/tag/counter registers stay in id_ex_reg.

Verification
REQ-029 Load: in_valid=1, instr=18'h0A508, dx=8'h11, no stall -> next edge ex_valid=1, ex_instr=18'h0A508, ex_dx=8'h11.
REQ-030 EX hazard: EX writes r5 (rf_wr=1), in ADRX=5 -> hz_stall=1, two bubbles, bubble_cnt 0->2, third cycle loads.
REQ-031 Flush+stall: flush=1, stall_in=1 with valid stage -> next edge ex_valid=0, ex_ctrl=0.
REQ-032 stall_in=1 for 3 cycles -> all ex_* and bubble_cnt unchanged; hazard during stall adds no count.
REQ-033 Saturation: force 300 hazards -> bubble_cnt=8'hFF.
REQ-034 rst_n low mid-bubble (asynchronous, between edges) -> all outputs zero immediately; after release, load at first edge.
